// File: rtl/runtime_unload_table.sv
// Outbound unloader: streams N phits from the upper half of the register file
// through a 2-entry skid FIFO to a valid/ready sink.
module runtime_unload_table #(
  parameter int PHIT_W    = 512,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 2**(ADDR_W-1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_unloader,
  input  logic [ADDR_W-1:0] num_entry_outbound,
  output logic              rd_en_RF,
  output logic [ADDR_W-1:0] rd_add_RF,
  input  logic [PHIT_W-1:0] rd_data_RF,
  output logic [PHIT_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done_unloader
);
  localparam int                HALF  = 2**(ADDR_W-1);
  localparam logic [ADDR_W-1:0] MAX_N = HALF[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] BASE  = BASE_ADDR[ADDR_W-1:0];

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] n_q, n_in, rd_idx, xfer_idx, rd_add_q;
  logic              inflight, done_run, done_zero;
  logic [PHIT_W-1:0] mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        occ;
  logic [2:0]        level;
  logic              push, pop, issue, last_rd, last_xfer, start_idle;

  always_comb begin
    n_in       = (num_entry_outbound > MAX_N) ? MAX_N : num_entry_outbound;
    start_idle = (state == IDLE) && start_unloader;
    push       = inflight;
    out_valid  = (occ != 2'd0);
    out_data   = mem[rd_ptr];
    pop        = out_valid && out_ready;
    // Occupancy is counted after this cycle's pop so a streaming sink keeps
    // one read issued per cycle; the returned word still always finds a slot.
    level      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    issue      = (state == READ) && (level < 3'd2);
    rd_en_RF   = issue;
    rd_add_RF  = issue ? (BASE + rd_idx) : rd_add_q;
    last_rd    = issue && (rd_idx == n_q - 1'b1);
    last_xfer  = pop && (xfer_idx == n_q - 1'b1);
    busy       = (state != IDLE) || done_run;
    done_unloader = done_run || done_zero;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_unloader && n_in != '0) state_nxt = READ;
      READ:    if (last_rd) state_nxt = DRAIN;
      DRAIN:   if (last_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n_q       <= '0;
      rd_idx    <= '0;
      xfer_idx  <= '0;
      rd_add_q  <= BASE;
      inflight  <= 1'b0;
      done_run  <= 1'b0;
      done_zero <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
      mem[0]    <= '0;
      mem[1]    <= '0;
    end else begin
      state     <= state_nxt;
      inflight  <= issue;
      done_run  <= (state == DRAIN) && last_xfer;
      done_zero <= start_idle && (n_in == '0);
      if (start_idle) begin
        n_q      <= n_in;
        rd_idx   <= '0;
        xfer_idx <= '0;
      end
      if (issue) begin
        rd_idx   <= rd_idx + 1'b1;
        rd_add_q <= rd_add_RF;
      end
      if (pop && state != IDLE) xfer_idx <= xfer_idx + 1'b1;
      if (push) begin
        mem[wr_ptr] <= rd_data_RF;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_runtime_unload_table.sv
// Randomized bench for runtime_unload_table: RF model, expected-phit queue,
// and per-cycle protocol checks against the unload rules.
module tb_runtime_unload_table;
  localparam int PHIT_W = 512;
  localparam int ADDR_W = 10;
  localparam int BASE   = 512;
  localparam int HALF   = 512;
  typedef logic [PHIT_W-1:0] w_t;

  logic              clk = 0, rst = 0, start_unloader = 0, out_ready = 0;
  logic [ADDR_W-1:0] num_entry_outbound = '0;
  logic              rd_en_RF, out_valid, busy, done_unloader;
  logic [ADDR_W-1:0] rd_add_RF;
  logic [PHIT_W-1:0] rd_data_RF = '0, out_data;

  runtime_unload_table #(.PHIT_W(PHIT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start_unloader(start_unloader),
    .num_entry_outbound(num_entry_outbound), .rd_en_RF(rd_en_RF),
    .rd_add_RF(rd_add_RF), .rd_data_RF(rd_data_RF), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done_unloader(done_unloader));

  always #5 clk = ~clk;

  w_t rf [2**ADDR_W];
  always @(posedge clk) if (rd_en_RF) rd_data_RF <= rf[rd_add_RF];

  int vecs = 0, errs = 0;
  w_t exp_q [$];
  int exp_n, rd_k, xfer, done_cnt, first_rd, first_ov, done_cyc;
  bit prev_stall, busy_seen, busy1, busy_done;
  w_t prev_data;
  int last_add;

  task automatic chk(input string tag, input w_t got, input w_t exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input bit rnd);
    for (int a = 0; a < 2**ADDR_W; a++) begin
      w_t wd = '0;
      if (rnd) for (int j = 1; j < PHIT_W/32; j++) wd[j*32 +: 32] = $urandom;
      wd[31:0] = 32'(a - BASE + 1);
      rf[a] = wd;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; start_unloader = 0; out_ready = 0;
    @(negedge clk);
    chk("rst_rd_en", w_t'(rd_en_RF), 0);
    chk("rst_out_valid", w_t'(out_valid), 0);
    chk("rst_busy", w_t'(busy), 0);
    chk("rst_done", w_t'(done_unloader), 0);
    chk("rst_rd_add", w_t'(rd_add_RF), w_t'(BASE));
    chk("rst_out_data", out_data, 0);
    @(posedge clk); #1; rst = 0;
    prev_stall = 0;
  endtask

  task automatic mon(input int t);
    if (rd_en_RF) begin
      if (rd_k >= exp_n) chk("rd_extra", w_t'(rd_k), w_t'(exp_n - 1));
      chk("rd_add", w_t'(rd_add_RF), w_t'((BASE + rd_k) % (2**ADDR_W)));
      last_add = int'(rd_add_RF);
      if (first_rd < 0) first_rd = t;
      rd_k++;
    end
    if (prev_stall) begin
      chk("hold_valid", w_t'(out_valid), 1);
      chk("hold_data", out_data, prev_data);
    end
    if (out_valid && first_ov < 0) first_ov = t;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("xfer_extra", w_t'(xfer), w_t'(exp_n));
      else chk("out_data", out_data, exp_q.pop_front());
      xfer++;
    end
    if (rd_en_RF) chk("outstanding_le2", w_t'(rd_k - xfer <= 2), 1);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (busy) busy_seen = 1;
    if (t == 1) busy1 = busy;
    if (done_unloader) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = t;
      busy_done = busy;
    end
  endtask

  // mode: 0 ready high, 1 random ready, 2 ready low for cycles 3..8
  task automatic run(input int n, input int mode, input int restart_at,
                     input int abort_at, input bit lat_chk);
    bit fin = 0;
    exp_n = (n > HALF) ? HALF : n;
    exp_q.delete();
    for (int k = 0; k < exp_n; k++) exp_q.push_back(rf[BASE + k]);
    rd_k = 0; xfer = 0; done_cnt = 0; first_rd = -1; first_ov = -1;
    done_cyc = -1; busy_seen = 0; busy1 = 0; busy_done = 0; last_add = -1;
    for (int t = 0; t < 4000 && !fin; t++) begin
      @(posedge clk); #1;
      start_unloader     = (t == 0) || (t == restart_at);
      num_entry_outbound = (t == 0) ? ADDR_W'(n) : ADDR_W'(3);
      case (mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = !(t >= 3 && t <= 8);
        default: out_ready = 1;
      endcase
      @(negedge clk);
      mon(t);
      if (abort_at >= 0 && xfer == abort_at) begin
        do_reset();
        exp_q.delete();
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("abort_rd_en", w_t'(rd_en_RF), 0);
          chk("abort_no_done", w_t'(done_unloader), 0);
        end
        chk("abort_done_cnt", w_t'(done_cnt), 0);
        return;
      end
      if (done_cnt > 0) fin = 1;
    end
    if (!fin) chk("timeout", 0, 1);
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1; start_unloader = 0; out_ready = 1;
      @(negedge clk); mon(100000);
    end
    chk("xfer_count", w_t'(xfer), w_t'(exp_n));
    chk("model_empty", w_t'(exp_q.size()), 0);
    chk("done_count", w_t'(done_cnt), 1);
    chk("busy_after", w_t'(busy), 0);
    if (exp_n == 0) begin
      chk("zero_done_cyc", w_t'(done_cyc), 1);
      chk("zero_no_read", w_t'(rd_k), 0);
      chk("zero_busy", w_t'(busy_seen), 0);
    end else begin
      chk("busy_t1", w_t'(busy1), 1);
      chk("busy_at_done", w_t'(busy_done), 1);
      chk("last_rd_add", w_t'(last_add), w_t'(BASE + exp_n - 1));
      if (lat_chk) begin
        chk("lat_first_rd", w_t'(first_rd), 1);
        chk("lat_first_ov", w_t'(first_ov), 3);
        chk("lat_done", w_t'(done_cyc), w_t'(exp_n + 3));
      end
    end
  endtask

  initial begin
    fill(0);
    rst = 1;
    #12;
    do_reset();
    run(4, 0, -1, -1, 1);
    run(3, 2, -1, -1, 0);
    run(0, 0, -1, -1, 0);
    run(5, 0, 2, -1, 0);
    run(6, 0, -1, 2, 0);
    run(2, 0, -1, -1, 1);
    fill(1);
    run(512, 1, -1, -1, 0);
    run(700, 0, -1, -1, 1);
    for (int i = 0; i < 4; i++) run(int'($urandom_range(1, 40)), 1, -1, -1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/runtime_unload_table.md
RUNTIME_UNLOAD_TABLE -- requirements
Module: runtime_unload_table

Interface
REQ-001 SHALL have parameter PHIT_W, default 512, phit width; equals the phit_size of the register file (RF) data word.
REQ-002 SHALL have parameter ADDR_W, default 10, RF address width (dwidth_RFadd).
REQ-003 SHALL have parameter BASE_ADDR, default 2**(ADDR_W-1), first RF address of the outbound region (upper half of each RF; inbound uses the lower half).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start_unloader  input  1  single-cycle start pulse.
REQ-007 SHALL have port num_entry_outbound  input  ADDR_W  number of phits to send; sampled only with start_unloader.
REQ-008 SHALL have port rd_en_RF  output  1  RF read strobe.
REQ-009 SHALL have port rd_add_RF  output  ADDR_W  RF read address.
REQ-010 SHALL have port rd_data_RF  input  PHIT_W  RF read data, valid exactly one cycle after rd_en_RF.
REQ-011 SHALL have port out_data  output  PHIT_W  outbound phit.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-014 SHALL have port busy  output  1  high from the cycle after an accepted start until the done pulse inclusive.
REQ-015 SHALL have port done_unloader  output  1  single-cycle pulse after the last transfer.

Function
REQ-016 SHALL implement the FSM states IDLE, READ and DRAIN.
REQ-017 IDLE -> READ SHALL occur on start_unloader with num_entry_outbound > 0; count and read index SHALL be latched at that edge.
REQ-018 In IDLE, start_unloader with num_entry_outbound == 0 SHALL produce a done_unloader pulse in the next cycle, with no read and busy low.
REQ-019 start_unloader asserted while not in IDLE SHALL be ignored.
REQ-020 Counts above 2**(ADDR_W-1) SHALL be clamped to 2**(ADDR_W-1).
REQ-021 The k-th read (k = 0..N-1) SHALL use rd_add_RF = (BASE_ADDR + k) mod 2**ADDR_W, issued in strictly increasing k order.
REQ-022 The block SHALL contain an internal 2-entry output FIFO.
REQ-023 rd_en_RF SHALL be asserted only when FIFO occupancy plus in-flight reads is less than 2, so no returned data is ever dropped.
REQ-024 Returned rd_data_RF SHALL be written into the FIFO on the cycle it is valid.
REQ-025 out_valid and out_data SHALL be driven from the FIFO head.
REQ-026 READ -> DRAIN SHALL occur when the N-th read has issued.
REQ-027 DRAIN -> IDLE SHALL occur when the N-th transfer completes.
REQ-028 done_unloader SHALL pulse in the cycle after the N-th transfer.
REQ-029 Latency: with start in cycle 0, the first rd_en_RF SHALL be in cycle 1 and the first out_valid in cycle 3.
REQ-030 With out_ready held high, the block SHALL sustain one phit per cycle.
REQ-031 While out_valid && !out_ready, out_data and out_valid SHALL hold stable.
REQ-032 out_valid SHALL never drop without a transfer.
REQ-033 A FIFO push and pop in the same cycle SHALL keep occupancy unchanged.
REQ-034 Phits SHALL exit in address order with no duplication or loss.
REQ-035 rd_add_RF SHALL hold its last value when rd_en_RF is low.

Reset
REQ-036 On rst, state SHALL be IDLE.
REQ-037 On rst, the FIFO SHALL be emptied and in-flight reads discarded.
REQ-038 On rst, rd_en_RF, out_valid, busy and done_unloader SHALL be 0.
REQ-039 On rst, rd_add_RF SHALL be BASE_ADDR and out_data SHALL be 0.
REQ-040 Reset asserted mid-transfer SHALL abort the operation with no done_unloader pulse.
REQ-041 After reset releases, the first accepted start SHALL begin again from BASE_ADDR.

Verification
REQ-042 Scenario: ADDR_W=10, N=4, out_ready=1, RF[512+k]=k+1 -> rd_add 512..515 in cycles 1-4; out_data 1,2,3,4 in cycles 3-6; done_unloader in cycle 7.
REQ-043 Scenario: N=3 with out_ready=0 for cycles 3-8 -> at most 2 reads outstanding or buffered; out_data=1 held stable; phits 1,2,3 delivered after ready rises; single done pulse.
REQ-044 Scenario: N=0 -> done_unloader in cycle 1; rd_en_RF never high; busy stays 0.
REQ-045 Scenario: second start during an N=5 run -> ignored; exactly 5 transfers and one done pulse.
REQ-046 Scenario: rst asserted after the 2nd transfer of N=6 -> all outputs 0 within the reset; no done pulse; a new start with N=2 reads from 512.
REQ-047 Scenario: out_ready toggling randomly, N=512 -> 512 phits in order, with the final read address 1023.
